// File: rtl/if_fetch_pkg.sv
// ============================================================================
// Module   : if_fetch_pkg
// Purpose  : Shared widths, constants and fetch-state encoding for if_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_pkg;

  localparam int          INST_ADDR_W      = 32;
  localparam int          INST_W           = 32;
  localparam int          BYTE_W           = 8;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic        RST_ENABLE       = 1'b1;
  localparam logic [2:0]  BYTES_PER_INST   = 3'd4;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_OUT   = 1'b1
  } fetch_state_e;

  // Little-endian lane insert: lane 0 holds the byte at the lowest address.
  function automatic logic [INST_W-1:0] insert_byte(
    input logic [INST_W-1:0] word,
    input logic [1:0]        lane,
    input logic [BYTE_W-1:0] data
  );
    logic [INST_W-1:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      default: res[31:24] = data;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch.sv
// ============================================================================
// Module   : if_fetch
// Purpose  : Instruction fetch; four byte reads per instruction, valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic [BYTE_W-1:0]      mem_rdata_i,
  output logic                   if_valid_o,
  input  logic                   if_ready_i,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o
);

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;
  logic [INST_ADDR_W-1:0] r_pc;
  logic [2:0]             r_issue_cnt;
  logic [2:0]             r_recv_cnt;
  logic                   r_pending;
  logic [INST_W-1:0]      r_inst_buf;
  logic                   r_if_valid;
  logic [INST_ADDR_W-1:0] r_if_pc;
  logic [INST_W-1:0]      r_if_inst;

  logic                   w_req;
  logic                   w_issue;
  logic                   w_transfer;
  logic                   w_last_byte;
  logic [INST_W-1:0]      w_buf_next;

  always_comb begin
    w_req        = 1'b0;
    w_issue      = 1'b0;
    w_transfer   = 1'b0;
    w_last_byte  = 1'b0;
    w_buf_next   = insert_byte(r_inst_buf, r_recv_cnt[1:0], mem_rdata_i);
    w_state_next = r_state;

    // A redirect suppresses the request so no byte of the old stream is issued.
    if ((rst != RST_ENABLE) && !branch_i && (r_state == ST_FETCH) &&
        (r_issue_cnt < BYTES_PER_INST)) begin
      w_req = 1'b1;
    end
    w_issue     = w_req & mem_gnt_i;
    w_transfer  = (r_state == ST_OUT) & r_if_valid & if_ready_i;
    w_last_byte = r_pending & (r_recv_cnt == 3'd3);

    if (branch_i) begin
      w_state_next = ST_FETCH;
    end else if (w_last_byte) begin
      w_state_next = ST_OUT;
    end else if (w_transfer) begin
      w_state_next = ST_FETCH;
    end
  end

  assign mem_req_o  = w_req;
  assign mem_addr_o = r_pc + {29'd0, r_issue_cnt};
  assign if_valid_o = r_if_valid;
  assign if_pc_o    = r_if_pc;
  assign if_inst_o  = r_if_inst;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 3'd0;
      r_pending   <= 1'b0;
      r_inst_buf  <= ZERO_WORD;
      r_if_valid  <= 1'b0;
      r_if_pc     <= ZERO_WORD;
      r_if_inst   <= ZERO_WORD;
    end else begin
      r_state <= w_state_next;
      if (branch_i) begin
        // Byte returning this cycle belongs to the abandoned stream; drop it.
        r_pc        <= branch_target_i;
        r_issue_cnt <= 3'd0;
        r_recv_cnt  <= 3'd0;
        r_pending   <= 1'b0;
        r_if_valid  <= 1'b0;
      end else begin
        r_pending <= w_issue;
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt + 3'd1;
        end
        if (r_pending) begin
          r_inst_buf <= w_buf_next;
          r_recv_cnt <= r_recv_cnt + 3'd1;
          if (w_last_byte) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            r_if_inst  <= w_buf_next;
          end
        end
        if (w_transfer) begin
          r_pc        <= r_pc + 32'd4;
          r_issue_cnt <= 3'd0;
          r_recv_cnt  <= 3'd0;
          r_if_valid  <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch.sv
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : Directed self-checking bench for if_fetch with a byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];

  logic        iss;
  logic [31:0] iss_addr;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rdata_i     (mem_rdata_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
            mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // Memory: a granted request returns its byte in the following cycle; junk otherwise.
  always @(negedge clk) begin
    iss      = mem_req_o & mem_gnt_i;
    iss_addr = mem_addr_o;
  end

  always @(posedge clk) begin
    #1;
    if (iss) mem_rdata_i = mem_byte(iss_addr);
    else     mem_rdata_i = 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && if_valid_o && if_ready_i && !branch_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc", if_pc_o, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", if_pc_o, e[63:32]);
        chk("sb_inst", if_inst_o, e[31:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!if_valid_o && n < max) begin
      cyc();
      n++;
    end
    chk("valid_timeout", {31'd0, if_valid_o}, 32'd1);
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    branch_i        = 1'b0;
    branch_target_i = 32'h0;
    mem_gnt_i       = 1'b0;
    if_ready_i      = 1'b0;
    mem_rdata_i     = 8'h00;

    repeat (3) cyc();
    chk("rst_req",   {31'd0, mem_req_o},  32'd0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_pc",    if_pc_o,   32'd0);
    chk("rst_inst",  if_inst_o, 32'd0);

    // Basic fetch from RESET_PC, full grant, ready high
    rst = 1'b0; mem_gnt_i = 1'b1; if_ready_i = 1'b1;
    #1;
    chk("a_req1",  {31'd0, mem_req_o}, 32'd1);
    chk("a_addr1", mem_addr_o, 32'd0);
    exp_q.push_back({32'd0, 32'h0010_0513});
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("a_addr", mem_addr_o, 32'(k));
    end
    cyc();
    chk("a_c5_req",   {31'd0, mem_req_o},  32'd0);
    chk("a_c5_valid", {31'd0, if_valid_o}, 32'd0);
    cyc();
    chk("a_c6_valid", {31'd0, if_valid_o}, 32'd1);
    chk("a_c6_inst",  if_inst_o, 32'h0010_0513);
    cyc();
    chk("a_c7_addr", mem_addr_o, 32'd4);
    chk("a_c7_req",  {31'd0, mem_req_o}, 32'd1);

    // Grant stall on byte 2, then hold ready low for 5 valid cycles
    if_ready_i = 1'b0;
    exp_q.push_back({32'd4, exp_inst(32'd4)});
    cyc();
    chk("b_addr5", mem_addr_o, 32'd5);
    cyc();
    mem_gnt_i = 1'b0;
    chk("b_addr6_s1", mem_addr_o, 32'd6);
    cyc();
    chk("b_addr6_s2", mem_addr_o, 32'd6);
    chk("b_req_s2", {31'd0, mem_req_o}, 32'd1);
    cyc();
    mem_gnt_i = 1'b1;
    chk("b_addr6_g", mem_addr_o, 32'd6);
    cyc();
    chk("b_addr7", mem_addr_o, 32'd7);
    cyc();
    chk("b_c13_valid", {31'd0, if_valid_o}, 32'd0);
    cyc();
    chk("b_c14_valid", {31'd0, if_valid_o}, 32'd1);
    chk("b_c14_inst",  if_inst_o, exp_inst(32'd4));
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("c_hold_valid", {31'd0, if_valid_o}, 32'd1);
      chk("c_hold_pc",    if_pc_o, 32'd4);
      chk("c_hold_inst",  if_inst_o, exp_inst(32'd4));
      chk("c_hold_req",   {31'd0, mem_req_o}, 32'd0);
    end
    cyc();
    if_ready_i = 1'b1;
    cyc();
    chk("c_next_addr", mem_addr_o, 32'd8);
    chk("c_next_valid", {31'd0, if_valid_o}, 32'd0);

    // Redirect while byte 1 of pc=8 returns
    cyc();
    cyc();
    branch_i = 1'b1; branch_target_i = 32'h0000_0100;
    #1;
    chk("d_req_br", {31'd0, mem_req_o}, 32'd0);
    cyc();
    branch_i = 1'b0;
    #1;
    chk("d_addr_tgt", mem_addr_o, 32'h100);
    chk("d_req_tgt",  {31'd0, mem_req_o}, 32'd1);
    chk("d_valid",    {31'd0, if_valid_o}, 32'd0);
    exp_q.push_back({32'h100, exp_inst(32'h100)});
    wait_valid(20, n);
    chk("d_latency", 32'(n), 32'd5);
    cyc();
    chk("d_next_addr", mem_addr_o, 32'h104);

    // Redirect coincident with transfer of pc=0x104
    wait_valid(20, n);
    chk("e_latency", 32'(n), 32'd5);
    branch_i = 1'b1; branch_target_i = 32'h0000_0200;
    #1;
    chk("e_req_br", {31'd0, mem_req_o}, 32'd0);
    cyc();
    branch_i = 1'b0;
    #1;
    chk("e_addr_tgt", mem_addr_o, 32'h200);
    chk("e_valid",    {31'd0, if_valid_o}, 32'd0);
    exp_q.push_back({32'h200, exp_inst(32'h200)});
    wait_valid(20, n);
    chk("e_latency2", 32'(n), 32'd5);
    cyc();
    chk("e_next_addr", mem_addr_o, 32'h204);

    // Unaligned target crossing the 2^32 boundary
    branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    cyc();
    branch_i = 1'b0;
    #1;
    chk("w_addr0", mem_addr_o, 32'hFFFF_FFFE);
    exp_q.push_back({32'hFFFF_FFFE, exp_inst(32'hFFFF_FFFE)});
    cyc();
    chk("w_addr1", mem_addr_o, 32'hFFFF_FFFF);
    cyc();
    chk("w_addr2", mem_addr_o, 32'h0000_0000);
    cyc();
    chk("w_addr3", mem_addr_o, 32'h0000_0001);
    wait_valid(20, n);
    chk("w_latency", 32'(n), 32'd2);
    cyc();
    chk("w_next_addr", mem_addr_o, 32'h0000_0002);

    // Reset mid-fetch
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("f_req_rst", {31'd0, mem_req_o}, 32'd0);
    cyc();
    chk("f_valid", {31'd0, if_valid_o}, 32'd0);
    chk("f_pc",    if_pc_o, 32'd0);
    chk("f_inst",  if_inst_o, 32'd0);
    chk("f_req",   {31'd0, mem_req_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk("f_addr_rst", mem_addr_o, 32'd0);
    chk("f_req_rel",  {31'd0, mem_req_o}, 32'd1);
    exp_q.push_back({32'd0, 32'h0010_0513});
    wait_valid(20, n);
    chk("f_latency", 32'(n), 32'd5);
    cyc();
    if_ready_i = 1'b0;
    chk("f_next_addr", mem_addr_o, 32'd4);

    repeat (8) cyc();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
